pe_code_fifo: RTL and testbench
===============================

# pe_code_fifo

Event queue directly downstream of the 8-input priority encoder. Samples the encoder's 4-bit code (0 = no request, 1..8 = highest active input), turns each new non-zero code into an event, and buffers events in a first-word-fall-through FIFO. A consumer drains the FIFO over a valid/ready handshake. Adds overflow and illegal-code status for the controlling logic.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- DEDUP, 1, 1 = enqueue only when the code changes; 0 = enqueue every non-zero sample
- clk  input  1  clock; all state updates on posedge (encoder output updates on negedge, so it is stable half a cycle before sampling)
- rst  input  1  asynchronous, active-high reset
- code_in  input  4  encoder code {o4,o3,o2,o1}
- clr  input  1  synchronous flush, same effect as reset
- out_code  output  4  head-of-queue code; 0 when empty
- out_valid  output  1  queue non-empty
- out_ready  input  1  consumer accepts head
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky; an event was dropped because the queue was full
- drop_cnt  output  8  dropped-event count, saturates at 255
- bad_code  output  1  sticky; code_in in 9..15 was sampled

## Operation
- Reset values: out_code 0, out_valid 0, level 0, overflow 0, drop_cnt 0, bad_code 0, last_code 0, read/write pointers 0.
- last_code register: loads code_in every cycle, including illegal codes and zero.
- Event on a cycle when code_in in 1..8 and (DEDUP=0 or code_in != last_code). A return to 0 followed by the same code is a new event.
- Illegal code 9..15: not enqueued, sets bad_code, counts as a change for dedup purposes.
- pop = out_valid & out_ready. push = event & (level < DEPTH or pop).
- Full with a simultaneous event and pop: both happen, level stays DEPTH, no overflow.
- Full with an event and no pop: event dropped, overflow set, drop_cnt += 1 (holds at 255).
- Push and pop on the same cycle with level between 1 and DEPTH-1: level unchanged.
- Empty with an event: no bypass. The entry becomes visible the next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. level carries the full/empty distinction.
- clr high: on that edge all state returns to reset values and any event or pop that cycle is discarded. last_code also returns to 0, so a held non-zero code re-enqueues after clr deasserts.
- Asynchronous rst mid-operation: all contents are lost immediately and outputs take reset values without waiting for clk.
- out_ready is ignored while out_valid is 0.

## Timing
- Capture latency: code_in sampled at posedge N gives out_valid=1 and out_code=code from posedge N onward, i.e. visible in cycle N+1.
- Handshake: the head stays stable while out_valid & !out_ready. Pop takes effect at the edge where both are high, and the next entry (or empty) appears after that edge.
- Throughput: one push and one pop per cycle.
- Status outputs are registered and update at the same edge as the triggering event.
- out_code is driven from FIFO storage and the read pointer, masked to 0 when level is 0. There is no combinational path from code_in.

## Test plan
- Reset then sequence 0,3,3,3,0,3 with DEDUP=1 and out_ready=0 -> level 2, queue holds 3,3, no overflow.
- DEDUP=0, DEPTH=8, code_in held at 5 for 10 cycles, out_ready=0 -> level 8, overflow=1, drop_cnt=2. Then drain with out_ready=1 -> eight 5s, out_valid falls after the 8th pop.
- Queue full, toggle code_in 2/7 every cycle with out_ready=1 -> level stays 8, overflow stays 0, output order matches input order.
- code_in=12 for one cycle then 4 -> bad_code=1, only 4 enqueued. Apply clr -> all status cleared and level 0.
- Load 3 entries, assert rst asynchronously between clock edges -> out_valid=0, level=0 immediately. After release with code_in held at 6, 6 is enqueued once.
- Hold 300 overflowing events -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/pe_code_fifo.sv
`timescale 1ns/1ps
// pe_code_fifo: converts priority-encoder codes into events and queues them
// in a first-word-fall-through FIFO drained over a valid/ready handshake.
// Also keeps sticky overflow/illegal-code status and a saturating drop count.
module pe_code_fifo #(
  parameter int DEPTH = 8,
  parameter bit DEDUP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             code_in,
  input  logic                   clr,
  output logic [3:0]             out_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
  output logic                   bad_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [3:0]    last_code_q, last_code_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          bad_code_q, bad_code_d;

  logic code_legal, code_illegal, code_change;
  logic evt, empty, full, pop, push, drop;

  // Event detection and handshake qualification.
  // A full queue still accepts an event when the head leaves on the same edge.
  always_comb begin
    code_legal   = (code_in != 4'd0) && (code_in <= 4'd8);
    code_illegal = (code_in > 4'd8);
    code_change  = (code_in != last_code_q);
    evt          = code_legal && (!DEDUP || code_change);
    empty        = (level_q == '0);
    full         = (level_q == FULL_LVL);
    pop          = !empty && out_ready;
    push         = evt && (!full || pop);
    drop         = evt && full && !pop;
  end

  // Next-state for pointers, occupancy and status.
  // last_code follows code_in unconditionally so illegal codes and zero
  // both break a run of identical codes.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q + LW'(push) - LW'(pop);
    last_code_d = code_in;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    bad_code_d  = bad_code_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
    if (code_illegal) begin
      bad_code_d = 1'b1;
    end
  end

  // State registers; clr behaves as a synchronous copy of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_code_q <= 4'd0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
      bad_code_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_code_q <= 4'd0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
      bad_code_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      bad_code_q  <= bad_code_d;
    end
  end

  // Storage needs no reset: stale entries are hidden because level gates the head.
  always_ff @(posedge clk) begin
    if (push && !clr && !rst) begin
      mem_q[wr_ptr_q] <= code_in;
    end
  end

  // Head of queue straight from storage, masked when empty.
  always_comb begin
    out_valid = !empty;
    out_code  = empty ? 4'd0 : mem_q[rd_ptr_q];
    level     = level_q;
    overflow  = overflow_q;
    drop_cnt  = drop_cnt_q;
    bad_code  = bad_code_q;
  end

endmodule

// File: tb/tb_pe_code_fifo.sv
`timescale 1ns/1ps
// Bench for pe_code_fifo: one deduplicating and one non-deduplicating
// instance share stimulus; a queue-based model predicts both every cycle.
module tb_pe_code_fifo;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = 4'd0;
  logic       clr = 1'b0;
  logic       out_ready = 1'b0;

  logic [3:0] u0_code, u1_code;
  logic       u0_valid, u1_valid;
  logic [3:0] u0_level, u1_level;
  logic       u0_ovf, u1_ovf;
  logic [7:0] u0_drop, u1_drop;
  logic       u0_bad, u1_bad;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pe_code_fifo #(.DEPTH(DEPTH), .DEDUP(1'b1)) u0 (
    .clk(clk), .rst(rst), .code_in(code_in), .clr(clr),
    .out_code(u0_code), .out_valid(u0_valid), .out_ready(out_ready),
    .level(u0_level), .overflow(u0_ovf), .drop_cnt(u0_drop), .bad_code(u0_bad)
  );

  pe_code_fifo #(.DEPTH(DEPTH), .DEDUP(1'b0)) u1 (
    .clk(clk), .rst(rst), .code_in(code_in), .clr(clr),
    .out_code(u1_code), .out_valid(u1_valid), .out_ready(out_ready),
    .level(u1_level), .overflow(u1_ovf), .drop_cnt(u1_drop), .bad_code(u1_bad)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: plain queues, one per instance.
  logic [3:0] mq0[$];
  logic [3:0] mq1[$];
  logic [3:0] m_last;
  int         m_ovf0, m_ovf1, m_dc0, m_dc1, m_bad;
  bit         m_legal, m_ev0, m_ev1;

  function automatic int head0();
    if (mq0.size() == 0) return 0;
    return int'(mq0[0]);
  endfunction

  function automatic int head1();
    if (mq1.size() == 0) return 0;
    return int'(mq1[0]);
  endfunction

  // Model update: pop first, then the event is accepted if room exists.
  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      mq0.delete(); mq1.delete();
      m_last = 4'd0;
      m_ovf0 = 0; m_ovf1 = 0; m_dc0 = 0; m_dc1 = 0; m_bad = 0;
    end else begin
      m_legal = (code_in >= 4'd1) && (code_in <= 4'd8);
      m_ev0   = m_legal && (code_in != m_last);
      m_ev1   = m_legal;
      if (mq0.size() > 0 && out_ready) void'(mq0.pop_front());
      if (mq1.size() > 0 && out_ready) void'(mq1.pop_front());
      if (m_ev0) begin
        if (mq0.size() < DEPTH) mq0.push_back(code_in);
        else begin m_ovf0 = 1; if (m_dc0 < 255) m_dc0++; end
      end
      if (m_ev1) begin
        if (mq1.size() < DEPTH) mq1.push_back(code_in);
        else begin m_ovf1 = 1; if (m_dc1 < 255) m_dc1++; end
      end
      if (code_in >= 4'd9) m_bad = 1;
      m_last = code_in;
    end
  end

  // Every-cycle comparison, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("u0_valid", u0_valid, mq0.size() != 0);
      chk("u0_code",  u0_code,  head0());
      chk("u0_level", u0_level, mq0.size());
      chk("u0_ovf",   u0_ovf,   m_ovf0);
      chk("u0_drop",  u0_drop,  m_dc0);
      chk("u0_bad",   u0_bad,   m_bad);
      chk("u1_valid", u1_valid, mq1.size() != 0);
      chk("u1_code",  u1_code,  head1());
      chk("u1_level", u1_level, mq1.size());
      chk("u1_ovf",   u1_ovf,   m_ovf1);
      chk("u1_drop",  u1_drop,  m_dc1);
      chk("u1_bad",   u1_bad,   m_bad);
    end
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic step(input logic [3:0] c, input logic r, input logic cl);
    code_in   = c;
    out_ready = r;
    clr       = cl;
    @(negedge clk);
  endtask

  initial begin
    int v;
    int rdy_pct;
    logic [3:0] c;
    int pcts [6];
    pcts = '{20, 80, 50, 95, 5, 50};

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_u0_valid", u0_valid, 0);
    chk("rst_u0_code",  u0_code,  0);
    chk("rst_u0_level", u0_level, 0);
    chk("rst_u1_ovf",   u1_ovf,   0);
    chk("rst_u1_drop",  u1_drop,  0);
    chk("rst_u1_bad",   u1_bad,   0);

    // 0,3,3,3,0,3: dedup queues two 3s, non-dedup queues four
    step(0, 0, 0); step(3, 0, 0); step(3, 0, 0);
    step(3, 0, 0); step(0, 0, 0); step(3, 0, 0);
    chk("t1_u0_level", u0_level, 2);
    chk("t1_u0_code",  u0_code,  3);
    chk("t1_u0_ovf",   u0_ovf,   0);
    chk("t1_u1_level", u1_level, 4);
    step(0, 0, 1);
    chk("clr_u0_level", u0_level, 0);

    // held 5 for 10 cycles overfills the non-dedup queue by two
    for (int i = 0; i < 10; i++) step(5, 0, 0);
    chk("t2_u1_level", u1_level, 8);
    chk("t2_u1_ovf",   u1_ovf,   1);
    chk("t2_u1_drop",  u1_drop,  2);
    chk("t2_u0_level", u0_level, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_valid", u1_valid, 1);
      chk("t2_drain_code",  u1_code,  5);
      step(0, 1, 0);
    end
    chk("t2_u1_empty", u1_valid, 0);
    chk("t2_u1_ovf_sticky", u1_ovf, 1);
    step(0, 0, 1);

    // full queue with simultaneous push and pop never overflows
    for (int i = 0; i < 8; i++) step(2, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step((i % 2) ? 4'd2 : 4'd7, 1, 0);
      chk("t3_u1_level", u1_level, 8);
    end
    chk("t3_u1_ovf",  u1_ovf,  0);
    chk("t3_u1_code", u1_code, 7);
    step(0, 0, 1);

    // illegal code sets bad_code and is not queued
    step(12, 0, 0); step(4, 0, 0);
    chk("t4_u0_bad",   u0_bad,   1);
    chk("t4_u0_level", u0_level, 1);
    chk("t4_u0_code",  u0_code,  4);
    chk("t4_u1_level", u1_level, 1);
    step(0, 0, 1);
    chk("t4_clr_bad",   u0_bad,   0);
    chk("t4_clr_level", u1_level, 0);

    // asynchronous reset between edges
    step(1, 0, 0); step(2, 0, 0); step(3, 0, 0);
    chk("t5_u0_level_pre", u0_level, 3);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", u0_valid, 0);
    chk("t5_async_level", u0_level, 0);
    chk("t5_async_u1",    u1_level, 0);
    @(negedge clk);
    rst = 1'b0;
    code_in = 4'd6;
    step(6, 0, 0); step(6, 0, 0); step(6, 0, 0);
    chk("t5_u0_level", u0_level, 1);
    chk("t5_u0_code",  u0_code,  6);
    chk("t5_u1_level", u1_level, 3);
    step(0, 0, 1);

    // 300 overflowing events saturate the drop counter
    for (int i = 0; i < 300; i++) step(1, 0, 0);
    chk("t6_u1_drop", u1_drop, 255);
    chk("t6_u1_ovf",  u1_ovf,  1);
    chk("t6_u0_drop", u0_drop, 0);
    step(0, 0, 1);

    // randomized phase
    rdy_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      rdy_pct = pcts[(i / 500) % 6];
      v = $urandom_range(0, 99);
      if (v < 40)      c = code_in;
      else if (v < 55) c = 4'd0;
      else if (v < 60) c = 4'(9 + $urandom_range(0, 6));
      else             c = 4'(1 + $urandom_range(0, 7));
      step(c, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 199) == 0));
      if (i == 1500) begin
        #3 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
